bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per parallel word; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: load_data  input  WIDTH  parallel word to serialize.
REQ-005 Port: load_valid  input  1  load_data is offered.
REQ-006 Port: load_ready  output  1  serializer accepts a word this cycle; combinational.
REQ-007 Port: bit_en  input  1  bit-rate tick; the current serial bit is consumed only on cycles with bit_en=1.
REQ-008 Port: serial_out  output  1  current serial bit, MSB first; registered.
REQ-009 Port: serial_valid  output  1  serial_out carries a word bit or a parity bit; registered.
REQ-010 Port: word_done  output  1  one-cycle pulse after the final bit of a word is consumed; registered.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and PARITY; PARITY exists only when the configuration macro is defined.
REQ-012 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; the word is captured into a WIDTH-bit shift register, and the bit counter is cleared to 0.
REQ-013 load_ready SHALL be 1 in IDLE, and also in the final-bit cycle with bit_en=1: SHIFT with counter=WIDTH-1 without parity, or PARITY with parity; load_ready SHALL be 0 otherwise.
REQ-014 On the cycle after acceptance: state=SHIFT, serial_valid=1, serial_out=load_data[WIDTH-1].
REQ-015 In SHIFT with bit_en=1 and counter<WIDTH-1: shift left by one, increment the counter, and set serial_out to the next lower bit.
REQ-016 In SHIFT or PARITY with bit_en=0: all state, serial_out and serial_valid SHALL hold.
REQ-017 At the final-bit cycle with bit_en=1: pulse word_done on the next cycle; if a new word is accepted in the same cycle, enter SHIFT with its MSB (no gap cycle); otherwise enter IDLE.
REQ-018 In IDLE: serial_out=0 and serial_valid=0.
REQ-019 Latency: acceptance to first bit on serial_out is 1 cycle; a word occupies exactly WIDTH bit_en ticks, or WIDTH+1 ticks with parity.
REQ-020 load_data and load_valid SHALL be ignored while load_ready=0; no data loss and no overwrite of the word in flight.
REQ-021 The counter SHALL be ceil(log2(WIDTH)) bits wide, SHALL never exceed WIDTH-1, and SHALL wrap to 0 only through a new acceptance.
REQ-022 An illegal state encoding SHALL return the FSM to IDLE on the next clock.

Reset
REQ-023 When rst=1 at a rising edge: state=IDLE, counter=0, shift register=0, serial_out=0, serial_valid=0, word_done=0.
REQ-024 rst SHALL override all other inputs, including a simultaneous load acceptance; a word in flight is discarded with no word_done pulse.
REQ-025 load_ready SHALL be 0 while rst=1.

Configuration
REQ-026 Macro SERIALIZER_PARITY_EN: when defined, even parity of the accepted word is computed at acceptance and transmitted as one extra bit in state PARITY after the LSB; serial_valid=1 during PARITY, and word_done follows the parity bit.
REQ-027 Without SERIALIZER_PARITY_EN: PARITY state and parity register are absent; word_done follows the LSB.

Verification
REQ-028 WIDTH=4, no parity, bit_en=1 always, load 4'b1011 once -> serial_out 1,0,1,1 on cycles 1-4, serial_valid=1 on cycles 1-4, word_done=1 on cycle 5, IDLE after.
REQ-029 WIDTH=4, load_valid held high with 4'b1011 then 4'b0110 -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; no gap; word_done pulses after bits 4 and 8.
REQ-030 WIDTH=4, bit_en=1 every third cycle, load 4'b1001 -> each bit held 3 cycles; load_ready=0 until the final tick; new load attempts during the word are ignored.
REQ-031 WIDTH=4, rst=1 asserted for one cycle during bit 2 -> next cycle serial_valid=0, serial_out=0, load_ready=1, no word_done; a following load of 4'b1111 serializes normally.
REQ-032 With SERIALIZER_PARITY_EN, WIDTH=4: load 4'b1011 -> bits 1,0,1,1,1 (even parity=1); load 4'b0110 -> bits 0,1,1,0,0; word_done follows the 5th bit.
REQ-033 WIDTH=4, 4'b1011 serialized back-to-back into the downstream 1011 detector -> detector output asserts after each completed 1011 pattern, including the overlap across word boundaries.

Source files
------------

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter paced by a bit_en tick, with back-to-back word chaining.
// Optional even-parity bit after the LSB when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on a rising edge where load_valid and load_ready are both 1;
  // load_ready never depends on load_valid, and offered data is ignored while load_ready is 0.

  localparam int CW = $clog2(WIDTH);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             final_tick;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign last_bit = (cnt == CW'(WIDTH - 1));
`ifdef SERIALIZER_PARITY_EN
  assign final_tick = (state_q == PARITY) && bit_en;
`else
  assign final_tick = (state_q == SHIFT) && last_bit && bit_en;
`endif
  assign accept = load_valid && load_ready;

  // The serial bit is the shift register MSB, so it is a flop output with no logic behind it.
  assign serial_out = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_en && last_bit) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_en) state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = !rst && ((state_q == IDLE) || final_tick);
    state_dbg  = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shreg        <= '0;
      serial_valid <= 1'b0;
      word_done    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      word_done <= final_tick;
      if (accept) begin
        shreg        <= load_data;
        cnt          <= '0;
        serial_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
        par_q        <= ^load_data;
`endif
      end else begin
        case (state_q)
          IDLE: begin
          end
          SHIFT: begin
            if (bit_en) begin
              if (!last_bit) begin
                shreg <= shreg << 1;
                cnt   <= cnt + CW'(1);
              end else begin
`ifdef SERIALIZER_PARITY_EN
                shreg <= {par_q, {(WIDTH-1){1'b0}}};
`else
                shreg        <= '0;
                serial_valid <= 1'b0;
`endif
              end
            end
          end
`ifdef SERIALIZER_PARITY_EN
          PARITY: begin
            if (bit_en) begin
              shreg        <= '0;
              serial_valid <= 1'b0;
            end
          end
`endif
          default: begin
            shreg        <= '0;
            serial_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
